// File: rtl/instr_field_queue.sv
// Purpose : DEPTH-entry IF/ID instruction queue presenting decoded MIPS fields of the head entry.
// Latency : 1 cycle push-to-head (0 cycles on an empty queue when IFQ_BYPASS_EN is defined).
// Backpr. : in_ready drops when full or during flush; a full queue blocks pushes even on a same-cycle pop.
//
// Optional feature macro: IFQ_BYPASS_EN (empty-queue fall-through from in_* to out_*).
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous queue clear on redirect (beats in_valid/out_ready)
//   in_valid/in_ready     fetch-side handshake carrying in_instr and in_pc
//   out_valid/out_ready   decode-side handshake for the head entry
//   out_pc, opcode..funct head PC and R/I/J field slices (all zero when out_valid = 0)
//   imm16, imm26          raw immediates of the head word
//   imm_sext/zext/lui     sign-, zero- and upper-extended imm16
//   count                 number of occupied entries
module instr_field_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm16,
  output logic [25:0]                imm26,
  output logic [31:0]                imm_sext,
  output logic [31:0]                imm_zext,
  output logic [31:0]                imm_lui,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic            empty;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;
  logic [31:0]     word;

  assign empty    = (cnt == '0);
  // No write-through when full: in_ready looks only at the current count.
  assign in_ready = (cnt < FULL_CNT) & ~flush;

`ifdef IFQ_BYPASS_EN
  // Empty queue: the incoming instruction is presented directly. If decode
  // takes it this cycle it is never written, otherwise it is stored as usual.
  logic bypass;
  assign bypass     = empty & in_valid & ~flush;
  assign out_valid  = (~empty | bypass) & ~flush;
  assign pop        = ~empty & out_valid & out_ready;
  assign push       = in_valid & in_ready & ~(bypass & out_ready);
  assign head_instr = bypass ? in_instr : mem_instr[rd_ptr];
  assign head_pc    = bypass ? in_pc    : mem_pc[rd_ptr];
`else
  assign out_valid  = ~empty & ~flush;
  assign pop        = out_valid & out_ready;
  assign push       = in_valid & in_ready;
  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];
`endif

  // Storage is untouched by flush; stale words are unreachable once pointers reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // An invalid head presents as a nop with PC 0.
  assign word   = out_valid ? head_instr : 32'h0;
  assign out_pc = out_valid ? head_pc : '0;

  assign opcode   = word[31:26];
  assign rs       = word[25:21];
  assign rt       = word[20:16];
  assign rd       = word[15:11];
  assign shamt    = word[10:6];
  assign funct    = word[5:0];
  assign imm16    = word[15:0];
  assign imm26    = word[25:0];
  assign imm_sext = {{16{word[15]}}, word[15:0]};
  assign imm_zext = {16'h0, word[15:0]};
  assign imm_lui  = {word[15:0], 16'h0};
  assign count    = cnt;

endmodule

// File: doc/instr_field_queue.md
Name: instr_field_queue

Overview:
- Parametrised successor to the combinational instruction-field splitter.
- Buffers fetched MIPS instructions, each with its PC, in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Presents the decoded fields and the extended immediates of the head entry to the decode stage.
- Sits between IF and ID. It decouples fetch from decode stalls and supports a pipeline flush on branch or jump redirect.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PC_W, 32, width of the stored PC.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous queue clear (redirect)
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept an instruction
- in_instr  input  32  instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes the head
- out_pc  output  PC_W  PC of the head
- opcode  output  6  head[31:26]
- rs  output  5  head[25:21]
- rt  output  5  head[20:16]
- rd  output  5  head[15:11]
- shamt  output  5  head[10:6]
- funct  output  6  head[5:0]
- imm16  output  16  head[15:0]
- imm26  output  26  head[25:0]
- imm_sext  output  32  sign-extended imm16
- imm_zext  output  32  zero-extended imm16
- imm_lui  output  32  {imm16, 16'h0}
- count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high. Ports are named clk and reset.
- On reset: read and write pointers = 0, count = 0, storage cleared, out_valid = 0. in_ready = 1 once reset deasserts.
- Push and pop conditions:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Handshake signals:
  - in_ready = (count < DEPTH) & ~flush.
  - out_valid = (count != 0) & ~flush.
- Latency: a pushed instruction appears at the head output on the cycle after the push edge (1-cycle latency).
- Field and immediate outputs:
  - Combinational slices of the head entry's stored word.
  - When out_valid = 0, every field, every immediate output and out_pc are forced to 0. The presented word is then 0x00000000 (nop).
- Simultaneous push and pop (count strictly between 0 and DEPTH): both pointers advance and count is unchanged.
- Full: a push is blocked when count = DEPTH, even if a pop occurs in the same cycle (no write-through-when-full). in_ready returns to 1 on the cycle after a pop frees an entry.
- Empty: out_valid = 0. out_ready is ignored.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Count: increments on push only, decrements on pop only. Never exceeds DEPTH and never underflows.
- Flush:
  - On the edge where flush = 1, pointers and count return to 0. Storage is left unchanged.
  - No push or pop happens in that cycle.
  - Flush has priority over in_valid and out_ready.
- Reset mid-operation: all state clears immediately and asynchronously, regardless of the handshake in progress.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count = 0 and in_valid = 1 and flush = 0, out_valid = 1 in the same cycle.
  - Fields, immediates and out_pc are taken from in_instr and in_pc.
  - If out_ready = 1, the instruction is consumed without being written and count stays 0.
  - If out_ready = 0, it is pushed normally.
- Undefined: no combinational path from in_* to out_*. The minimum latency is 1 cycle.

Test Plan:
- Single lw:
  - Stimulus: after reset, push 0x8C8A0004 / pc 0x00003000 with out_ready = 0.
  - Required response, next cycle: out_valid = 1, opcode = 0x23, rs = 4, rt = 10, imm16 = 0x0004, imm_sext = 0x00000004, out_pc = 0x00003000, count = 1.
- Negative immediate:
  - Stimulus: push 0x2108FFFF.
  - Required response: opcode = 0x08, rs = rt = 8, imm_sext = 0xFFFFFFFF, imm_zext = 0x0000FFFF, imm_lui = 0xFFFF0000.
- R-type with simultaneous traffic:
  - Stimulus: push 0x01095020 (add $t2,$t0,$t1), then hold in_valid and out_ready both high with count = 2.
  - Required response: rd = 10, funct = 0x20, shamt = 0; count stays 2 and head words emerge in push order.
- Full and wrap:
  - Stimulus: with DEPTH = 4, push 4 words, then pop 1 and push 1.
  - Required response: in_ready = 0 after the 4th push and count = 4; after the pop, the 5th word pushes and pops 2..5 return in order across the pointer wrap.
- Flush and reset:
  - Flush stimulus: count = 3, assert flush alongside in_valid and out_ready.
  - Flush response: next cycle count = 0, out_valid = 0, all fields = 0, no entry consumed.
  - Reset stimulus: assert reset asynchronously mid-cycle with count = 2.
  - Reset response: outputs clear before the next edge.
- Bypass (IFQ_BYPASS_EN defined):
  - Stimulus: empty queue, in_valid = out_ready = 1 with in_instr 0x3C011234.
  - Required response: same cycle out_valid = 1, opcode = 0x0F, imm_lui = 0x12340000, and count remains 0.
  - Without the macro, out_valid rises one cycle later.
